// File: rtl/serial_add_sub_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : serial_add_sub_ctrl
//  Purpose  : Bit-serial adder/subtractor. One operation computes a+b or a-b
//             one bit per clock, LSB first, through a single 1-bit full adder.
//             Subtraction is done as a + ~b + 1 (carry register preset to 1).
//  Ports    : clk        - sole clock, rising edge
//             rst_n      - asynchronous active-low reset
//             start      - begin an operation (honoured only in IDLE)
//             sub        - 0: a+b, 1: a-b (sampled with start)
//             a, b       - WIDTH-bit operands (sampled with start)
//             busy       - high while bits are being computed (RUN)
//             done       - one-cycle pulse when result is updated (DONE)
//             result     - last completed sum/difference
//             carry_out  - final carry of last operation (sub: 1 = no borrow)
//             overflow   - signed overflow of last operation
//  Revision : 1.0 - initial release
// ============================================================================
module serial_add_sub_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow
);

    localparam int                c_cnt_w = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_next_state;

    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    // Holds the WIDTH-1 lower sum bits; the top bit is taken straight from
    // the adder on the final edge, so no extra register stage is needed.
    logic [WIDTH-2:0]     r_sum;
    logic                 r_carry;
    logic [c_cnt_w-1:0]   r_cnt;

    logic                 w_sum;
    logic                 w_cout;
    logic                 w_last;
    logic [WIDTH-1:0]     w_sum_full;

    // Single full adder on the operand LSBs
    assign w_sum      = r_a[0] ^ r_b[0] ^ r_carry;
    assign w_cout     = (r_a[0] & r_b[0]) | (r_a[0] & r_carry) | (r_b[0] & r_carry);
    assign w_last     = (r_state == S_RUN) && (r_cnt == c_last);
    assign w_sum_full = {w_sum, r_sum};

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next_state = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (w_last) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                done         = 1'b1;
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a       <= '0;
            r_b       <= '0;
            r_sum     <= '0;
            r_carry   <= 1'b0;
            r_cnt     <= '0;
            result    <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b ^ {WIDTH{sub}};
                        r_carry <= sub;
                        r_cnt   <= '0;
                    end
                end
                S_RUN: begin
                    r_a     <= r_a >> 1;
                    r_b     <= r_b >> 1;
                    r_sum   <= w_sum_full[WIDTH-1:1];
                    r_carry <= w_cout;
                    // Counter saturates at the last bit so it never wraps.
                    if (r_cnt != c_last) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                    if (w_last) begin
                        result    <= w_sum_full;
                        carry_out <= w_cout;
                        // r_carry is the carry into the MSB at this point
                        overflow  <= r_carry ^ w_cout;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_add_sub_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_add_sub_ctrl
//  Purpose  : Self-checking bench for serial_add_sub_ctrl (WIDTH = 8):
//             table of directed add/sub vectors plus hand-written sequences
//             for start-ignore, mid-run reset and back-to-back operation.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_serial_add_sub_ctrl;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             carry_out;
    logic             overflow;

    int n_pass;
    int n_total;

    typedef struct {
        logic             sub;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] res;
        logic             co;
        logic             ov;
    } vec_t;

    vec_t vecs[8];

    serial_add_sub_ctrl #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .sub       (sub),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Present an operation at a negedge; returns at the negedge after E0.
    task automatic launch(input logic s, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        start = 1'b1;
        sub   = s;
        a     = x;
        b     = y;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called at the negedge after E0: checks the busy window, done pulse,
    // the results and the return to IDLE. Returns at the negedge after E9.
    task automatic check_run(input string name, input logic [WIDTH-1:0] er,
                             input logic eco, input logic eov);
        int bad;
        bad = 0;
        for (int k = 0; k < WIDTH; k++) begin
            if (busy !== 1'b1 || done !== 1'b0) bad++;
            @(negedge clk);
        end
        chk({name, "_busy_window"}, bad, 0);
        chk({name, "_done"}, {busy, done}, 2'b01);
        chk({name, "_result"}, result, er);
        chk({name, "_carry"}, carry_out, eco);
        chk({name, "_ovf"}, overflow, eov);
        @(negedge clk);
        chk({name, "_idle"}, {busy, done}, 2'b00);
    endtask

    initial begin
        int bad;
        int ndone;
        int t_done[3];
        logic [WIDTH-1:0] exp_q[3];

        n_pass  = 0;
        n_total = 0;

        //            sub   a      b      res    co    ov
        vecs[0] = '{1'b0, 8'h05, 8'h03, 8'h08, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1};
        vecs[3] = '{1'b1, 8'h03, 8'h05, 8'hFE, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1};
        vecs[5] = '{1'b1, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0};
        vecs[6] = '{1'b0, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1};
        vecs[7] = '{1'b1, 8'h7F, 8'hFF, 8'h80, 1'b0, 1'b1};

        rst_n = 1'b0;
        start = 1'b0;
        sub   = 1'b0;
        a     = '0;
        b     = '0;

        // Reset state
        @(negedge clk);
        chk("reset_outputs", {busy, done, result, carry_out, overflow}, '0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed vectors
        for (int i = 0; i < 8; i++) begin
            launch(vecs[i].sub, vecs[i].a, vecs[i].b);
            check_run($sformatf("vec%0d", i), vecs[i].res, vecs[i].co, vecs[i].ov);
        end

        // Start re-pulsed during RUN and during DONE must be ignored;
        // result must hold the previous value until completion.
        launch(1'b0, 8'h10, 8'h20);
        bad = 0;
        for (int k = 0; k < WIDTH; k++) begin
            if (busy !== 1'b1 || done !== 1'b0) bad++;
            if (k == 2) begin
                chk("ign_hold_result", result, 8'h80);
                start = 1'b1;
                sub   = 1'b1;
                a     = 8'h11;
                b     = 8'h22;
            end else if (k == 3) begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        chk("ign_busy_window", bad, 0);
        chk("ign_done", {busy, done}, 2'b01);
        chk("ign_result", result, 8'h30);
        chk("ign_flags", {carry_out, overflow}, 2'b00);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("ign_done_low", done, 1'b0);
        @(negedge clk);
        chk("ign_no_restart", busy, 1'b0);
        chk("ign_result_held", result, 8'h30);

        // Reset during RUN cycle 4
        launch(1'b0, 8'h40, 8'h40);
        repeat (3) @(negedge clk);
        chk("rst_busy_before", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("rst_async_outputs", {busy, done, result, carry_out, overflow}, '0);
        bad = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (busy !== 1'b0 || done !== 1'b0 || result !== 8'h00) bad++;
        end
        chk("rst_held_quiet", bad, 0);
        rst_n = 1'b1;
        launch(1'b0, 8'h01, 8'h01);
        check_run("post_rst", 8'h02, 1'b0, 1'b0);

        // Start held high: three back-to-back operations
        exp_q[0] = 8'h04;
        exp_q[1] = 8'h05;
        exp_q[2] = 8'h06;
        t_done[0] = 0;
        t_done[1] = 0;
        t_done[2] = 0;
        ndone = 0;
        start = 1'b1;
        sub   = 1'b0;
        a     = 8'h01;
        b     = 8'h03;
        for (int cyc = 0; cyc < 40 && ndone < 3; cyc++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                t_done[ndone] = cyc;
                chk($sformatf("held_result%0d", ndone), result, exp_q[ndone]);
                ndone++;
                a = a + 8'h01;
            end
        end
        start = 1'b0;
        chk("held_done_count", ndone, 3);
        chk("held_first_latency", t_done[0], 8);
        chk("held_spacing01", t_done[1] - t_done[0], 10);
        chk("held_spacing12", t_done[2] - t_done[1], 10);
        repeat (2) @(negedge clk);
        chk("held_final_idle", {busy, done}, 2'b00);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
